// File: rtl/k_means_div_scheduler_if.sv
// Signal bundle between the k-means center-update scheduler and its memories/divider.
// The master side is the scheduler; the slave side is the surrounding operator.
interface k_means_div_scheduler_if #(
    parameter int NUM_CLUSTER   = 8,
    parameter int NUM_DIM       = 16,
    parameter int MAX_DIM_WIDTH = 32
);
    logic                                    start_update;
    logic [$clog2(NUM_CLUSTER):0]            cfg_num_cluster;
    logic [$clog2(NUM_DIM):0]                cfg_data_dim;
    logic                                    sum_rd_en;
    logic [$clog2(NUM_CLUSTER*NUM_DIM)-1:0]  sum_rd_addr;
    logic [63:0]                             sum_rd_data;
    logic [$clog2(NUM_CLUSTER)-1:0]          cnt_rd_addr;
    logic [63:0]                             cnt_rd_data;
    logic [63:0]                             div_sum;
    logic [63:0]                             div_count;
    logic                                    div_valid;
    logic                                    div_last_dim;
    logic                                    div_last;
    logic [MAX_DIM_WIDTH-1:0]                div_dout;
    logic                                    div_dout_valid;
    logic                                    div_dout_last_dim;
    logic                                    div_dout_last;
    logic                                    center_wr_en;
    logic [$clog2(NUM_CLUSTER*NUM_DIM)-1:0]  center_wr_addr;
    logic [MAX_DIM_WIDTH-1:0]                center_wr_data;
    logic [NUM_CLUSTER-1:0]                  empty_mask;
    logic                                    busy;
    logic                                    update_done;
    logic                                    err_sticky;
    logic [31:0]                             drop_cnt;

    modport master (
        input  start_update, cfg_num_cluster, cfg_data_dim, sum_rd_data, cnt_rd_data,
               div_dout, div_dout_valid, div_dout_last_dim, div_dout_last,
        output sum_rd_en, sum_rd_addr, cnt_rd_addr, div_sum, div_count, div_valid,
               div_last_dim, div_last, center_wr_en, center_wr_addr, center_wr_data,
               empty_mask, busy, update_done, err_sticky, drop_cnt
    );

    modport slave (
        output start_update, cfg_num_cluster, cfg_data_dim, sum_rd_data, cnt_rd_data,
               div_dout, div_dout_valid, div_dout_last_dim, div_dout_last,
        input  sum_rd_en, sum_rd_addr, cnt_rd_addr, div_sum, div_count, div_valid,
               div_last_dim, div_last, center_wr_en, center_wr_addr, center_wr_data,
               empty_mask, busy, update_done, err_sticky, drop_cnt
    );
endinterface

// File: rtl/k_means_div_scheduler.sv
// Streams accumulated sums/counts through the shared divider and writes the
// returned quotients into center memory, tracking empty clusters and stray returns.
module k_means_div_scheduler #(
    parameter int NUM_CLUSTER   = 8,
    parameter int NUM_DIM       = 16,
    parameter int MAX_DIM_WIDTH = 32,
    parameter int DIV_LATENCY   = 41
) (
    input logic                      clk,
    input logic                      rst,
    k_means_div_scheduler_if.master  bus
);
    localparam int AW  = $clog2(NUM_CLUSTER * NUM_DIM);
    localparam int CAW = $clog2(NUM_CLUSTER);
    localparam int CW  = $clog2(NUM_CLUSTER) + 1;
    localparam int DW  = $clog2(NUM_DIM) + 1;

    if (DIV_LATENCY < 1) begin : g_bad_latency
        $error("DIV_LATENCY must be at least 1");
    end

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;
    state_t state, state_nxt;

    logic [CW-1:0]          cfg_clu, ic, wc;
    logic [DW-1:0]          cfg_dim, id, wd;
    logic                   cfg_zero, id_last, ic_last, wd_last;
    logic                   accept, rd_en, wr_en, drop, tag_err;
    logic                   vld_p1, last_dim_p1, last_p1;
    logic [CAW-1:0]         clu_p1;
    logic [NUM_CLUSTER-1:0] empty_mask;
    logic                   err_sticky;
    logic [31:0]            drop_cnt;

    assign cfg_zero = (cfg_clu == '0) || (cfg_dim == '0);
    assign id_last  = (id == cfg_dim - DW'(1));
    assign ic_last  = (ic == cfg_clu - CW'(1));
    assign wd_last  = (wd == cfg_dim - DW'(1));
    assign tag_err  = wr_en && (bus.div_dout_last_dim != wd_last);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        rd_en     = 1'b0;
        wr_en     = 1'b0;
        drop      = 1'b0;
        case (state)
            IDLE: begin
                drop = bus.div_dout_valid;
                if (bus.start_update) begin
                    accept    = 1'b1;
                    state_nxt = ISSUE;
                end
            end
            ISSUE: begin
                wr_en = bus.div_dout_valid;
                // A zero-sized pass spends one busy cycle here and issues nothing.
                if (cfg_zero) state_nxt = DONE;
                else begin
                    rd_en = 1'b1;
                    if (id_last && ic_last) state_nxt = DRAIN;
                end
            end
            DRAIN: begin
                wr_en = bus.div_dout_valid;
                if (bus.div_dout_valid && bus.div_dout_last) state_nxt = DONE;
            end
            DONE: begin
                drop      = bus.div_dout_valid;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Read and write address walkers share the dim-inner, cluster-outer geometry.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cfg_clu <= '0;
            cfg_dim <= '0;
            ic      <= '0;
            id      <= '0;
            wc      <= '0;
            wd      <= '0;
        end else if (accept) begin
            cfg_clu <= bus.cfg_num_cluster;
            cfg_dim <= bus.cfg_data_dim;
            ic      <= '0;
            id      <= '0;
            wc      <= '0;
            wd      <= '0;
        end else begin
            if (rd_en) begin
                if (id_last) begin
                    id <= '0;
                    ic <= ic + CW'(1);
                end else begin
                    id <= id + DW'(1);
                end
            end
            if (wr_en) begin
                if (wd_last) begin
                    wd <= '0;
                    wc <= wc + CW'(1);
                end else begin
                    wd <= wd + DW'(1);
                end
            end
        end
    end

    // Stage p1: strobe and tags aligned with the 1-cycle memory read data.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_p1      <= 1'b0;
            last_dim_p1 <= 1'b0;
            last_p1     <= 1'b0;
            clu_p1      <= '0;
        end else begin
            vld_p1      <= rd_en;
            last_dim_p1 <= rd_en && id_last;
            last_p1     <= rd_en && id_last && ic_last;
            clu_p1      <= ic[CAW-1:0];
        end
    end

    // A start that coincides with a stray return still records that return.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            empty_mask <= '0;
            err_sticky <= 1'b0;
            drop_cnt   <= '0;
        end else if (accept) begin
            empty_mask <= '0;
            err_sticky <= drop;
            drop_cnt   <= {31'd0, drop};
        end else begin
            if (vld_p1 && (bus.cnt_rd_data == 64'd0)) empty_mask[clu_p1] <= 1'b1;
            if (drop || tag_err) err_sticky <= 1'b1;
            if (drop) drop_cnt <= drop_cnt + 32'd1;
        end
    end

    assign bus.sum_rd_en      = rd_en;
    assign bus.sum_rd_addr    = AW'(int'(ic) * NUM_DIM + int'(id));
    assign bus.cnt_rd_addr    = ic[CAW-1:0];
    assign bus.div_valid      = vld_p1;
    assign bus.div_last_dim   = last_dim_p1;
    assign bus.div_last       = last_p1;
    assign bus.div_sum        = vld_p1 ? bus.sum_rd_data : 64'd0;
    assign bus.div_count      = vld_p1 ? bus.cnt_rd_data : 64'd0;
    assign bus.center_wr_en   = wr_en;
    assign bus.center_wr_addr = wr_en ? AW'(int'(wc) * NUM_DIM + int'(wd)) : '0;
    assign bus.center_wr_data = wr_en ? bus.div_dout : '0;
    assign bus.empty_mask     = empty_mask;
    assign bus.busy           = (state == ISSUE) || (state == DRAIN);
    assign bus.update_done    = (state == DONE);
    assign bus.err_sticky     = err_sticky;
    assign bus.drop_cnt       = drop_cnt;
endmodule

// File: tb/tb_k_means_div_scheduler.sv
// Scoreboard bench for k_means_div_scheduler: memory and fixed-latency divider models,
// expected issues/writes queued at start, compared as the scheduler produces them.
`timescale 1ns/1ps
module tb_k_means_div_scheduler;
    localparam int NC  = 8;
    localparam int ND  = 16;
    localparam int MW  = 32;
    localparam int LAT = 41;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    k_means_div_scheduler_if #(.NUM_CLUSTER(NC), .NUM_DIM(ND), .MAX_DIM_WIDTH(MW)) bus ();

    k_means_div_scheduler #(
        .NUM_CLUSTER(NC), .NUM_DIM(ND), .MAX_DIM_WIDTH(MW), .DIV_LATENCY(LAT)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    // Memory models with one-cycle read latency.
    logic [63:0] sum_mem [NC*ND];
    logic [63:0] cnt_mem [NC];
    always @(posedge clk) begin
        if (bus.sum_rd_en) bus.sum_rd_data <= sum_mem[bus.sum_rd_addr];
        bus.cnt_rd_data <= cnt_mem[bus.cnt_rd_addr];
    end

    // Divider model: never reset, so a scheduler reset leaves stale items in flight.
    logic          pv  [LAT] = '{default: 1'b0};
    logic [MW-1:0] pq  [LAT];
    logic          pld [LAT] = '{default: 1'b0};
    logic          pl  [LAT] = '{default: 1'b0};
    int iss_cnt     = 0;
    int corrupt_idx = -1;
    always @(posedge clk) begin
        for (int j = LAT - 1; j > 0; j--) begin
            pv[j]  <= pv[j-1];
            pq[j]  <= pq[j-1];
            pld[j] <= pld[j-1];
            pl[j]  <= pl[j-1];
        end
        pv[0]  <= bus.div_valid;
        pq[0]  <= (bus.div_count == 64'd0) ? '0 : MW'(bus.div_sum / bus.div_count);
        pld[0] <= bus.div_last_dim ^ (bus.div_valid && (iss_cnt == corrupt_idx));
        pl[0]  <= bus.div_last;
        if (bus.div_valid) iss_cnt <= iss_cnt + 1;
    end
    assign bus.div_dout_valid    = pv[LAT-1];
    assign bus.div_dout          = pq[LAT-1];
    assign bus.div_dout_last_dim = pld[LAT-1];
    assign bus.div_dout_last     = pl[LAT-1];

    typedef struct packed {
        logic [63:0] s;
        logic [63:0] c;
        logic        ld;
        logic        l;
    } iss_t;
    typedef struct packed {
        logic [31:0]   a;
        logic [MW-1:0] d;
    } wr_t;
    iss_t iss_q [$];
    wr_t  wr_q  [$];

    // Monitor: cumulative counters and last-seen cycle stamps, sampled on the falling edge.
    int cyc = 0;
    int start_cyc = 0;
    int rd_cnt = 0, dv_cnt = 0, wr_cnt = 0, done_cnt = 0, busy_cnt = 0, ovl_cnt = 0;
    int dv_first = 0, dv_last = 0, done_cyc = 0;
    logic dv_prev = 1'b0;
    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        dv_prev <= bus.div_valid;
        if (bus.sum_rd_en) rd_cnt <= rd_cnt + 1;
        if (bus.busy) busy_cnt <= busy_cnt + 1;
        if (bus.div_valid) begin
            dv_cnt <= dv_cnt + 1;
            if (!dv_prev) dv_first <= cyc;
            dv_last <= cyc;
            if (iss_q.size() == 0) chk("div_unexpected", 1, 0);
            else begin
                chk("div_sum", bus.div_sum, iss_q[0].s);
                chk("div_count", bus.div_count, iss_q[0].c);
                chk("div_last_dim", bus.div_last_dim, iss_q[0].ld);
                chk("div_last", bus.div_last, iss_q[0].l);
                void'(iss_q.pop_front());
            end
        end
        if (bus.center_wr_en) begin
            wr_cnt <= wr_cnt + 1;
            if (bus.sum_rd_en) ovl_cnt <= ovl_cnt + 1;
            if (wr_q.size() == 0) chk("wr_unexpected", 1, 0);
            else begin
                chk("wr_addr", bus.center_wr_addr, wr_q[0].a);
                chk("wr_data", bus.center_wr_data, wr_q[0].d);
                void'(wr_q.pop_front());
            end
        end
        if (bus.update_done) begin
            done_cnt <= done_cnt + 1;
            done_cyc <= cyc;
        end
    end

    task automatic push_expect(input int nc, input int nd, input bit with_writes);
        iss_t e;
        wr_t  w;
        for (int c = 0; c < nc; c++) begin
            for (int d = 0; d < nd; d++) begin
                e.s  = sum_mem[c*ND+d];
                e.c  = cnt_mem[c];
                e.ld = (d == nd - 1);
                e.l  = (d == nd - 1) && (c == nc - 1);
                iss_q.push_back(e);
                if (with_writes) begin
                    w.a = 32'(c*ND + d);
                    w.d = (cnt_mem[c] == 64'd0) ? '0 : MW'(sum_mem[c*ND+d] / cnt_mem[c]);
                    wr_q.push_back(w);
                end
            end
        end
    endtask

    task automatic start_pulse(input int nc, input int nd);
        @(negedge clk);
        bus.cfg_num_cluster = ($clog2(NC)+1)'(nc);
        bus.cfg_data_dim    = ($clog2(ND)+1)'(nd);
        bus.start_update    = 1'b1;
        @(posedge clk);
        #1;
        bus.start_update = 1'b0;
        start_cyc = cyc;
    endtask

    // One full pass; inj > 0 fires a foreign start (cfg 1x1) at that relative cycle.
    task automatic run_pass(input int nc, input int nd, input bit exp_err, input int inj);
        int n, r0, dv0, w0, b0, ov0, dn0;
        logic [NC-1:0] m;
        n = nc * nd;
        m = '0;
        if (n > 0)
            for (int c = 0; c < nc; c++) if (cnt_mem[c] == 64'd0) m[c] = 1'b1;
        push_expect(nc, nd, 1'b1);
        r0 = rd_cnt; dv0 = dv_cnt; w0 = wr_cnt; b0 = busy_cnt; ov0 = ovl_cnt; dn0 = done_cnt;
        start_pulse(nc, nd);
        chk("drop_cleared", bus.drop_cnt, 0);
        chk("err_cleared", bus.err_sticky, 0);
        for (int k = 2; k < 400 && done_cnt == dn0; k++) begin
            @(negedge clk);
            if (k == inj) begin
                bus.start_update    = 1'b1;
                bus.cfg_num_cluster = 1;
                bus.cfg_data_dim    = 1;
            end else begin
                bus.start_update = 1'b0;
            end
        end
        bus.start_update = 1'b0;
        if (done_cnt == dn0) chk("done_timeout", 0, 1);
        repeat (3) @(negedge clk);
        chk("done_cycle", done_cyc - start_cyc + 1, (n == 0) ? 2 : n + LAT + 2);
        chk("done_pulses", done_cnt - dn0, 1);
        chk("rd_count", rd_cnt - r0, n);
        chk("dv_count", dv_cnt - dv0, n);
        if (n > 0) begin
            chk("dv_first", dv_first - start_cyc + 1, 2);
            chk("dv_last", dv_last - start_cyc + 1, n + 1);
        end
        chk("wr_count", wr_cnt - w0, n);
        chk("busy_cycles", busy_cnt - b0, (n == 0) ? 1 : n + LAT + 1);
        chk("overlap", (ovl_cnt - ov0) > 0, n > LAT);
        chk("queues_left", iss_q.size() + wr_q.size(), 0);
        chk("empty_mask", bus.empty_mask, m);
        chk("err_sticky", bus.err_sticky, exp_err);
        chk("drop_cnt", bus.drop_cnt, 0);
        chk("busy_end", bus.busy, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int w0;
        bus.start_update    = 1'b0;
        bus.cfg_num_cluster = '0;
        bus.cfg_data_dim    = '0;
        for (int i = 0; i < NC*ND; i++) sum_mem[i] = 64'd0;
        for (int i = 0; i < NC; i++) cnt_mem[i] = 64'd1;

        repeat (3) @(negedge clk);
        chk("rst_busy", bus.busy, 0);
        chk("rst_done", bus.update_done, 0);
        chk("rst_mask", bus.empty_mask, 0);
        chk("rst_drop", bus.drop_cnt, 0);
        chk("rst_err", bus.err_sticky, 0);
        chk("rst_rd_en", bus.sum_rd_en, 0);
        chk("rst_wr_en", bus.center_wr_en, 0);
        rst = 1'b0;
        @(negedge clk);
        chk("idle_busy", bus.busy, 0);

        // Basic 2x3 pass: quotients 2,4,6,4,5,6.
        for (int d = 0; d < 3; d++) begin
            sum_mem[d]      = 64'(10 * (d + 1));
            sum_mem[ND + d] = 64'(10 * (d + 4));
        end
        cnt_mem[0] = 64'd5;
        cnt_mem[1] = 64'd10;
        run_pass(2, 3, 1'b0, -1);

        // Empty cluster 1.
        cnt_mem[1] = 64'd0;
        run_pass(2, 3, 1'b0, -1);
        cnt_mem[1] = 64'd10;

        // Full geometry with one empty cluster; returns overlap issue.
        for (int i = 0; i < NC*ND; i++) sum_mem[i] = 64'($urandom);
        for (int i = 0; i < NC; i++) cnt_mem[i] = 64'($urandom_range(1, 50));
        cnt_mem[3] = 64'd0;
        run_pass(8, 16, 1'b0, -1);

        // Foreign start while busy must be ignored.
        run_pass(2, 3, 1'b0, 10);

        // Zero-size passes.
        run_pass(3, 0, 1'b0, -1);
        run_pass(0, 4, 1'b0, -1);

        // Reset mid-issue with exactly five items already handed to the divider.
        push_expect(8, 16, 1'b0);
        w0 = wr_cnt;
        start_pulse(8, 16);
        repeat (6) @(posedge clk);
        #1;
        rst = 1'b1;
        @(negedge clk);
        chk("midrst_busy", bus.busy, 0);
        chk("midrst_rd_en", bus.sum_rd_en, 0);
        chk("midrst_dv", bus.div_valid, 0);
        rst = 1'b0;
        iss_q.delete();
        repeat (60) @(negedge clk);
        chk("stale_drop_cnt", bus.drop_cnt, 5);
        chk("stale_err", bus.err_sticky, 1);
        chk("stale_writes", wr_cnt - w0, 0);
        run_pass(2, 3, 1'b0, -1);

        // Third return of the next pass comes back with its last-dim tag flipped.
        corrupt_idx = iss_cnt + 2;
        run_pass(2, 3, 1'b1, -1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
